// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package dcache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        UPDATE,
        FLUSH
    } dcache_state_e;

    localparam int BLOCK_WORDS = 4;
    localparam int OFFSET_BITS = 4;
    localparam int WORD_BITS   = 32;
    localparam int BLOCK_BITS  = BLOCK_WORDS * WORD_BITS;

    function automatic int tag_bits(input int addr_width, input int index_bits);
        return addr_width - index_bits - OFFSET_BITS;
    endfunction

    function automatic int block_addr_bits(input int addr_width);
        return addr_width - OFFSET_BITS;
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays of the cache: one full-line write port and a
// combinational read of the indexed line.
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [BLOCK_BITS-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic                  wr_valid,
    input  logic                  wr_dirty,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [BLOCK_BITS-1:0] wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]      valid_q;
    logic [LINES-1:0]      dirty_q;
    logic [TAG_BITS-1:0]   tag_q  [LINES];
    logic [BLOCK_BITS-1:0] data_q [LINES];

    // Only the state bits need reset; tag/data are meaningless while invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= wr_valid;
            dirty_q[wr_index] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller with a
// block-wide main-memory port and a whole-cache flush.
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              mem_read,
    input  logic                              mem_write,
    input  logic [ADDR_WIDTH-1:0]             address,
    input  logic [WORD_BITS-1:0]              write_data,
    output logic [WORD_BITS-1:0]              read_data,
    output logic                              busy,
    input  logic                              flush,
    output logic                              flush_done,
    output logic                              mm_read,
    output logic                              mm_write,
    output logic [ADDR_WIDTH-OFFSET_BITS-1:0] mm_address,
    output logic [BLOCK_BITS-1:0]             mm_writedata,
    input  logic [BLOCK_BITS-1:0]             mm_readdata,
    input  logic                              mm_busywait
);

    // Handshakes: the pipeline holds mem_read/mem_write (and address/data)
    // until a cycle with busy=0, in which the access completes. Toward main
    // memory, mm_read/mm_write plus address/data stay stable until an edge
    // with mm_busywait=0, which is the transfer's single completion edge.

    localparam int TAG_BITS = tag_bits(ADDR_WIDTH, INDEX_BITS);
    localparam logic [INDEX_BITS-1:0] LAST_IDX = '1;

    dcache_state_e state;
    dcache_state_e state_next;

    logic [INDEX_BITS-1:0] flush_idx;
    logic [INDEX_BITS-1:0] flush_idx_next;
    logic                  flushing;
    logic                  flushing_next;
    logic [BLOCK_BITS-1:0] fill_data;

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [1:0]            word_sel;
    logic [INDEX_BITS-1:0] line_idx;
    logic                  hit;
    logic [WORD_BITS-1:0]  hit_word;
    logic [BLOCK_BITS-1:0] merged_line;

    logic                  rd_valid;
    logic                  rd_dirty;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [BLOCK_BITS-1:0] rd_data;
    logic                  wr_en;
    logic                  wr_valid;
    logic                  wr_dirty;
    logic [TAG_BITS-1:0]   wr_tag;
    logic [BLOCK_BITS-1:0] wr_data;

    logic unused_byte_offset;
    assign unused_byte_offset = ^address[1:0];

    assign req_idx  = address[OFFSET_BITS +: INDEX_BITS];
    assign req_tag  = address[ADDR_WIDTH-1 -: TAG_BITS];
    assign word_sel = address[OFFSET_BITS-1:2];

    // While flushing, the walk counter selects the line instead of the request.
    assign line_idx = flushing ? flush_idx : req_idx;
    assign hit      = rd_valid && (rd_tag == req_tag);
    assign hit_word = rd_data[{word_sel, 5'd0} +: WORD_BITS];

    always_comb begin
        merged_line = rd_data;
        merged_line[{word_sel, 5'd0} +: WORD_BITS] = write_data;
    end

    dcache_line_store #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_line_store (
        .clk     (clk),
        .reset   (reset),
        .rd_index(line_idx),
        .rd_valid(rd_valid),
        .rd_dirty(rd_dirty),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_index(line_idx),
        .wr_valid(wr_valid),
        .wr_dirty(wr_dirty),
        .wr_tag  (wr_tag),
        .wr_data (wr_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            flush_idx <= '0;
            flushing  <= 1'b0;
            fill_data <= '0;
        end else begin
            state     <= state_next;
            flush_idx <= flush_idx_next;
            flushing  <= flushing_next;
            if (state == ALLOCATE && !mm_busywait) begin
                fill_data <= mm_readdata;
            end
        end
    end

    always_comb begin
        state_next     = state;
        flush_idx_next = flush_idx;
        flushing_next  = flushing;
        busy           = 1'b0;
        flush_done     = 1'b0;
        read_data      = '0;
        mm_read        = 1'b0;
        mm_write       = 1'b0;
        mm_address     = '0;
        mm_writedata   = '0;
        wr_en          = 1'b0;
        wr_valid       = rd_valid;
        wr_dirty       = rd_dirty;
        wr_tag         = rd_tag;
        wr_data        = rd_data;

        unique case (state)
            IDLE: begin
                if (flush) begin
                    busy           = 1'b1;
                    flushing_next  = 1'b1;
                    flush_idx_next = '0;
                    state_next     = FLUSH;
                end else if (mem_read || mem_write) begin
                    if (!hit) begin
                        busy       = 1'b1;
                        state_next = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
                    end else if (mem_write) begin
                        wr_en    = 1'b1;
                        wr_valid = 1'b1;
                        wr_dirty = 1'b1;
                        wr_data  = merged_line;
                    end else begin
                        read_data = hit_word;
                    end
                end
            end

            WRITEBACK: begin
                busy         = 1'b1;
                mm_write     = 1'b1;
                mm_address   = {rd_tag, line_idx};
                mm_writedata = rd_data;
                if (!mm_busywait) begin
                    if (flushing) begin
                        // Line is now clean; FLUSH revisits it and advances.
                        wr_en      = 1'b1;
                        wr_valid   = 1'b0;
                        wr_dirty   = 1'b0;
                        state_next = FLUSH;
                    end else begin
                        state_next = ALLOCATE;
                    end
                end
            end

            ALLOCATE: begin
                busy       = 1'b1;
                mm_read    = 1'b1;
                mm_address = address[ADDR_WIDTH-1:OFFSET_BITS];
                if (!mm_busywait) begin
                    state_next = UPDATE;
                end
            end

            UPDATE: begin
                busy       = 1'b1;
                wr_en      = 1'b1;
                wr_valid   = 1'b1;
                wr_dirty   = 1'b0;
                wr_tag     = req_tag;
                wr_data    = fill_data;
                state_next = IDLE;
            end

            FLUSH: begin
                busy = 1'b1;
                if (rd_valid && rd_dirty) begin
                    state_next = WRITEBACK;
                end else begin
                    wr_en    = 1'b1;
                    wr_valid = 1'b0;
                    wr_dirty = 1'b0;
                    if (flush_idx == LAST_IDX) begin
                        flush_done    = 1'b1;
                        flushing_next = 1'b0;
                        state_next    = IDLE;
                    end else begin
                        flush_idx_next = flush_idx + 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios plus random loads/stores/flushes
// against a flat-memory reference and a block-residency model.
module tb_dcache_controller;

    localparam int W = 156;

    logic         clk;
    logic         reset;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  address;
    logic [31:0]  write_data;
    logic [31:0]  read_data;
    logic         busy;
    logic         flush;
    logic         flush_done;
    logic         mm_read;
    logic         mm_write;
    logic [27:0]  mm_address;
    logic [127:0] mm_writedata;
    logic [127:0] mm_readdata;
    logic         mm_busywait;

    dcache_controller dut (
        .clk         (clk),
        .reset       (reset),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .busy        (busy),
        .flush       (flush),
        .flush_done  (flush_done),
        .mm_read     (mm_read),
        .mm_write    (mm_write),
        .mm_address  (mm_address),
        .mm_writedata(mm_writedata),
        .mm_readdata (mm_readdata),
        .mm_busywait (mm_busywait)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- counters / scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int exp_ptr = 0;
    int got_ptr = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- initial memory image ----------------
    function automatic logic [31:0] init_word(input logic [29:0] w);
        if (w[29:2] == 28'h004) begin
            case (w[1:0])
                2'd0:    return 32'hAAAA_AAAA;
                2'd1:    return 32'hBBBB_BBBB;
                2'd2:    return 32'hCCCC_CCCC;
                default: return 32'hDDDD_DDDD;
            endcase
        end
        return {w[15:0] ^ 16'hC3A5, w[15:0]};
    endfunction

    // ---------------- main memory responder ----------------
    int mem_wait = 0;
    int mm_cnt = 0;
    int overlap_cnt = 0;
    logic [27:0] last_rd_blk = '0;
    logic [127:0] mm_mem [logic [27:0]];

    function automatic logic [127:0] mem_block(input logic [27:0] blk);
        if (mm_mem.exists(blk)) return mm_mem[blk];
        return {init_word({blk, 2'd3}), init_word({blk, 2'd2}),
                init_word({blk, 2'd1}), init_word({blk, 2'd0})};
    endfunction

    initial begin
        mm_busywait = 1'b0;
        mm_readdata = '0;
    end

    always @(posedge clk) begin
        if ((mm_read || mm_write) && !mm_busywait) begin
            if (mm_write) begin
                mm_mem[mm_address] = mm_writedata;
                got_q.push_back({mm_address, mm_writedata});
            end else begin
                last_rd_blk = mm_address;
            end
            mm_cnt = 0;
        end else if (mm_read || mm_write) begin
            mm_cnt++;
        end else begin
            mm_cnt = 0;
        end
    end

    always @(negedge clk) begin
        if (mm_read && mm_write) overlap_cnt++;
        mm_busywait = (mm_read || mm_write) && (mm_cnt < mem_wait);
        mm_readdata = mem_block(mm_address);
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [logic [29:0]];
    logic [27:0] res_blk [8];
    bit          res_valid [8];
    bit          res_dirty [8];

    function automatic logic [31:0] ref_word(input logic [29:0] w);
        if (ref_mem.exists(w)) return ref_mem[w];
        return init_word(w);
    endfunction

    function automatic logic [127:0] ref_block(input logic [27:0] blk);
        return {ref_word({blk, 2'd3}), ref_word({blk, 2'd2}),
                ref_word({blk, 2'd1}), ref_word({blk, 2'd0})};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            res_valid[i] = 1'b0;
            res_dirty[i] = 1'b0;
            res_blk[i]   = '0;
        end
    endtask

    // Cycles with busy=1: hit 0, clean miss 3+w, dirty miss 4+2w (w = memory wait cycles).
    task automatic model_access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                output int lat, output logic [31:0] rd);
        logic [27:0] blk;
        int idx;
        blk = addr[31:4];
        idx = int'(blk % 8);
        if (res_valid[idx] && res_blk[idx] == blk) begin
            lat = 0;
        end else begin
            if (res_valid[idx] && res_dirty[idx]) begin
                exp_q.push_back({res_blk[idx], ref_block(res_blk[idx])});
                lat = 4 + 2 * mem_wait;
            end else begin
                lat = 3 + mem_wait;
            end
            res_valid[idx] = 1'b1;
            res_dirty[idx] = 1'b0;
            res_blk[idx]   = blk;
        end
        rd = ref_word(addr[31:2]);
        if (wr) begin
            ref_mem[addr[31:2]] = data;
            res_dirty[idx] = 1'b1;
        end
    endtask

    task automatic model_flush();
        for (int i = 0; i < 8; i++) begin
            if (res_valid[i] && res_dirty[i]) exp_q.push_back({res_blk[i], ref_block(res_blk[i])});
            res_valid[i] = 1'b0;
            res_dirty[i] = 1'b0;
        end
    endtask

    task automatic drain_sb();
        check("wb_count", got_q.size(), exp_q.size());
        while (got_ptr < got_q.size() && exp_ptr < exp_q.size()) begin
            check("wb_block", got_q[got_ptr][155:128], exp_q[exp_ptr][155:128]);
            check("wb_data", got_q[got_ptr][127:0], exp_q[exp_ptr][127:0]);
            got_ptr++;
            exp_ptr++;
        end
        got_ptr = got_q.size();
        exp_ptr = exp_q.size();
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             output int lat, output logic [31:0] rd);
        int exp_lat;
        logic [31:0] exp_rd;
        model_access(wr, addr, data, exp_lat, exp_rd);
        @(negedge clk);
        mem_read   = !wr;
        mem_write  = wr;
        address    = addr;
        write_data = data;
        #1;
        lat = 0;
        while (busy === 1'b1 && lat < 300) begin
            @(negedge clk);
            #1;
            lat++;
        end
        rd = read_data;
        check("latency", lat, exp_lat);
        if (!wr) check("load_data", rd, exp_rd);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        drain_sb();
    endtask

    task automatic do_flush();
        int cyc;
        model_flush();
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_busy", busy, 1'b1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        cyc = 0;
        while (flush_done !== 1'b1 && cyc < 1000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check("flush_done", flush_done, 1'b1);
        @(negedge clk);
        #1;
        check("flush_done_pulse", flush_done, 1'b0);
        check("flush_idle_busy", busy, 1'b0);
        drain_sb();
    endtask

    // ---------------- stimulus ----------------
    int lat;
    logic [31:0] rd;
    logic [24:0] tag;

    initial begin
        reset      = 1'b1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        address    = '0;
        write_data = '0;
        flush      = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_mm_read", mm_read, 1'b0);
        check("rst_mm_write", mm_write, 1'b0);
        check("rst_read_data", read_data, 32'h0);
        check("rst_mm_address", mm_address, 28'h0);
        check("rst_mm_writedata", mm_writedata, 128'h0);
        reset = 1'b0;

        // clean miss with two wait cycles, then hits in the same block
        mem_wait = 2;
        do_access(1'b0, 32'h0000_0040, 32'h0, lat, rd);
        check("dir_clean_miss_lat", lat, 5);
        check("dir_rd_40", rd, 32'hAAAA_AAAA);
        do_access(1'b0, 32'h0000_0044, 32'h0, lat, rd);
        check("dir_hit_lat", lat, 0);
        check("dir_rd_44", rd, 32'hBBBB_BBBB);
        do_access(1'b1, 32'h0000_0040, 32'h1234_5678, lat, rd);
        check("dir_store_hit_lat", lat, 0);
        do_access(1'b0, 32'h0000_0040, 32'h0, lat, rd);
        check("dir_rd_after_store", rd, 32'h1234_5678);

        // conflict on index 4 evicts the dirty block 0x004
        do_access(1'b0, 32'h0000_0440, 32'h0, lat, rd);
        check("dir_dirty_miss_lat", lat, 8);
        check("dir_alloc_blk", last_rd_blk, 28'h044);
        check("dir_wb_cnt", got_q.size(), 1);
        check("dir_wb_blk", got_q[0][155:128], 28'h004);
        check("dir_wb_data", got_q[0][127:0],
              {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'h1234_5678});

        // dirty lines 1 and 6, then flush
        mem_wait = 0;
        do_access(1'b1, 32'h0000_0010, 32'hCAFE_0001, lat, rd);
        check("dir_store_miss_lat", lat, 3);
        do_access(1'b1, 32'h0000_0064, 32'hCAFE_0006, lat, rd);
        do_flush();
        check("dir_flush_wb_cnt", got_q.size(), 3);
        check("dir_flush_wb1", got_q[1][155:128], 28'h001);
        check("dir_flush_wb6", got_q[2][155:128], 28'h006);
        do_access(1'b0, 32'h0000_0010, 32'h0, lat, rd);
        check("dir_post_flush_miss", lat, 3);
        check("dir_post_flush_data", rd, 32'hCAFE_0001);

        // long stall in ALLOCATE, then reset mid-transfer
        mem_wait = 20;
        @(negedge clk);
        mem_read = 1'b1;
        address  = 32'h0000_0080;
        #1;
        check("stall_miss_busy", busy, 1'b1);
        @(negedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            check("stall_mm_read", mm_read, 1'b1);
            check("stall_mm_addr", mm_address, 28'h008);
            check("stall_busy", busy, 1'b1);
            @(negedge clk);
            #1;
        end
        reset    = 1'b1;
        mem_read = 1'b0;
        @(negedge clk);
        #1;
        check("rst_mid_mm_read", mm_read, 1'b0);
        check("rst_mid_mm_write", mm_write, 1'b0);
        check("rst_mid_busy", busy, 1'b0);
        reset = 1'b0;
        model_reset();
        mem_wait = 1;
        do_access(1'b0, 32'h0000_0010, 32'h0, lat, rd);
        check("rst_line_invalid", lat, 4);

        // random traffic over a few conflicting tags
        for (int n = 0; n < 200; n++) begin
            mem_wait = $urandom_range(0, 3);
            if ($urandom_range(0, 19) == 0) begin
                do_flush();
            end else begin
                case ($urandom_range(0, 3))
                    0:       tag = 25'h0;
                    1:       tag = 25'h1;
                    2:       tag = 25'h2;
                    default: tag = 25'h1ABCD;
                endcase
                do_access(1'($urandom_range(0, 1)),
                          {tag, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00},
                          $urandom(), lat, rd);
            end
        end
        do_flush();

        check("rw_overlap", overlap_cnt, 0);
        check("wb_total", got_q.size(), exp_q.size());
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
